alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Parametrised, pipelined successor to the combinational ALU operand wrapper. It keeps the same operand-select rules: ST, LD and the immediate ops route imm to operand B, and MOVEL/MOVEH mask imm. It adds registered results, a valid/ready handshake on both sides, and an iterative unsigned divider. It sits between decode/register read and writeback, and stalls decode through in_ready while a divide is in progress.

Parameters:
WIDTH, 32, datapath width in bits; even, at least 8.
OPW, 5, opcode width; all opcode encodings below are zero-extended to OPW.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operation presented.
in_ready  out  1  unit can accept an operation this cycle.
a  in  WIDTH  register operand A.
b  in  WIDTH  register operand B.
imm  in  WIDTH  sign/zero-extended immediate from decode.
opcode  in  OPW  instruction opcode.
out_valid  out  1  result registers hold a valid result.
out_ready  in  1  writeback consumes the result.
result  out  WIDTH  registered result.
flags  out  2  [1]=N (result MSB), [0]=Z (result==0).
div0  out  1  the result came from DIV with divisor 0.
illegal  out  1  the opcode is not in the supported set.

Behaviour:
- Opcodes: ADD=00010, ADDI=00011, SUB=00100, SUBI=00101, MUL=00110, MOVEH=00111, DIV=01000, AND=01010, ANDI=01011, OR=01100, ORI=01101, NOT=01110, XOR=10000, XORI=10001, CMP=10010, ST=11100, LD=11101, MOVEL=11110.
- Operand select:
  - ST: A=b, B=imm.
  - LD, ADDI, SUBI, ANDI, ORI, XORI: A=a, B=imm.
  - MOVEL: A=imm, B=low-half mask (WIDTH/2 ones in the low bits).
  - MOVEH: A=imm, B=high-half mask.
  - All other opcodes: A=a, B=b.
- Operations:
  - ADD/ADDI/LD/ST: A+B, modulo 2^WIDTH.
  - SUB/SUBI/CMP: A-B, modulo 2^WIDTH.
  - MUL: low WIDTH bits of the unsigned product A*B.
  - AND/ANDI/MOVEL/MOVEH: A&B.
  - OR/ORI: A|B.
  - XOR/XORI: A^B.
  - NOT: ~A.
  - DIV: unsigned A/B quotient.
- Illegal opcode: result=0, illegal=1, flags computed from result (Z=1, N=0).
- Flags and div0 are registered together with result.
- FSM states: IDLE, DIV_RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid with a non-DIV opcode: compute the result, register it, go to DONE.
  - On in_valid with DIV: latch the operands, clear the remainder and counter, go to DIV_RUN.
- DIV_RUN:
  - in_ready=0.
  - Restoring radix-2 divide, one quotient bit per cycle, MSB first.
  - Runs exactly WIDTH cycles, then registers the quotient and goes to DONE.
  - Divisor 0 still runs WIDTH cycles; result is all ones and div0=1.
- DONE:
  - out_valid=1.
  - result, flags, div0 and illegal hold stable until out_ready=1.
  - in_ready = out_ready.
  - On out_ready with in_valid: accept the new op in the same cycle and follow the IDLE rules (back-to-back, no bubble).
  - On out_ready without in_valid: go to IDLE.
- Latency from the accept edge to out_valid:
  - 1 cycle for non-DIV ops.
  - WIDTH+1 cycles for DIV.
- Throughput with out_ready tied high: one non-DIV op per cycle.
- Operands a, b, imm and opcode are sampled only on the accept edge (in_valid && in_ready); later changes are ignored.
- Reset: asynchronous, any state including mid-divide.
  - State goes to IDLE.
  - out_valid=0, result=0, flags=0, div0=0, illegal=0, divider counter and registers=0.
  - in_ready=1 immediately after rst_n deasserts.
- in_valid while in_ready=0 is ignored; upstream holds the op.

Test Plan:
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> one cycle later out_valid=1, result=0, flags=01.
- ADDI a=5, imm=0xFFFFFFFE; then MOVEL imm=0x12345678 back-to-back, out_ready=1 -> result 3 then 0x00005678; in_ready stays 1, no bubble.
- DIV a=100, b=7 -> in_ready=0 for 32 cycles, out_valid on cycle 33, result=14. DIV a=9, b=0 -> result=0xFFFFFFFF, div0=1, flags=10.
- SUB a=3, b=5 with out_ready=0 for 4 cycles -> result=0xFFFFFFFE, flags=10, held stable; in_ready=0 until out_ready rises.
- Opcode 11111 -> illegal=1, result=0, flags=01. ST b=0x1000, imm=0x10 -> result=0x1010.
- Assert rst_n=0 at divide cycle 10 -> out_valid=0 at once; after release in_ready=1 and ADD 2+2 yields 4.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU stage between decode/register read and
// writeback, with an iterative restoring unsigned divider.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operation handshake from decode
//   a, b, imm, opcode   operands and opcode, sampled only on accept
//   out_valid/out_ready result handshake to writeback
//   result, flags       registered result, flags = {N, Z}
//   div0                result came from DIV with a zero divisor
//   illegal             opcode is not in the supported set
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low. result/flags/div0/illegal stay stable while out_valid is
// high and out_ready is low. in_ready never depends on in_valid.

module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags,
  output logic             div0,
  output logic             illegal
);

  localparam logic [OPW-1:0] OP_ADD   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_SUBI  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_MOVEH = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_OR    = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_NOT   = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_XORI  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_CMP   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_ST    = OPW'(5'b11100);
  localparam logic [OPW-1:0] OP_LD    = OPW'(5'b11101);
  localparam logic [OPW-1:0] OP_MOVEL = OPW'(5'b11110);

  localparam logic [WIDTH-1:0] LO_MASK = {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};
  localparam logic [WIDTH-1:0] HI_MASK = ~LO_MASK;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, is_div;
  logic [WIDTH-1:0] op_a, op_b, alu_res;
  logic             legal;

  // divider state: dvd_q shifts the dividend out and the quotient in
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_shift, trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign accept = in_valid && in_ready;
  assign is_div = (opcode == OP_DIV);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = is_div ? S_DIV_RUN : S_DONE;
      S_DIV_RUN: if (cnt_q == LAST_STEP) state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (accept) state_nxt = is_div ? S_DIV_RUN : S_DONE;
          else        state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    out_valid = (state == S_DONE);
  end

  // ---------------- operand select and single-cycle ALU ----------------
  always_comb begin
    op_a    = a;
    op_b    = b;
    legal   = 1'b1;
    alu_res = '0;
    case (opcode)
      OP_ST:                                    begin op_a = b;   op_b = imm;     end
      OP_LD, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI,
      OP_XORI:                                  begin             op_b = imm;     end
      OP_MOVEL:                                 begin op_a = imm; op_b = LO_MASK; end
      OP_MOVEH:                                 begin op_a = imm; op_b = HI_MASK; end
      default: ;
    endcase
    case (opcode)
      OP_ADD, OP_ADDI, OP_LD, OP_ST:            alu_res = op_a + op_b;
      OP_SUB, OP_SUBI, OP_CMP:                  alu_res = op_a - op_b;
      OP_MUL:                                   alu_res = op_a * op_b;
      OP_AND, OP_ANDI, OP_MOVEL, OP_MOVEH:      alu_res = op_a & op_b;
      OP_OR, OP_ORI:                            alu_res = op_a | op_b;
      OP_XOR, OP_XORI:                          alu_res = op_a ^ op_b;
      OP_NOT:                                   alu_res = ~op_a;
      OP_DIV:                                   alu_res = '0; // produced by the divider
      default:                                  legal   = 1'b0;
    endcase
  end

  // ---------------- restoring divide step ----------------
  // A zero divisor never borrows, so every quotient bit comes out 1.
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    q_bit     = ~trial[WIDTH];
    rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {dvd_q[WIDTH-2:0], q_bit};
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      flags   <= '0;
      div0    <= 1'b0;
      illegal <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      if (is_div) begin
        dvd_q <= a;
        dvs_q <= b;
        rem_q <= '0;
        cnt_q <= '0;
      end else begin
        result  <= alu_res;
        flags   <= {alu_res[WIDTH-1], (alu_res == '0)};
        div0    <= 1'b0;
        illegal <= ~legal;
      end
    end else if (state == S_DIV_RUN) begin
      dvd_q <= quo_next;
      rem_q <= rem_next;
      cnt_q <= cnt_q + CW'(1);
      // the last quotient bit is folded straight into the result register
      if (cnt_q == LAST_STEP) begin
        result  <= quo_next;
        flags   <= {quo_next[WIDTH-1], (quo_next == '0)};
        div0    <= (dvs_q == '0);
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0, imm = '0;
  logic [4:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [1:0]   flags;
  logic         div0;
  logic         illegal;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(W), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .imm(imm), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .div0(div0), .illegal(illegal)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // returns {illegal, div0, flags[1:0], result}
  function automatic logic [35:0] model(input logic [4:0] op, input logic [31:0] x, y, z);
    logic [31:0] r;
    logic        il, d0;
    logic [63:0] p;
    r = 0; il = 0; d0 = 0;
    case (op)
      5'b00010: r = x + y;
      5'b00011: r = x + z;
      5'b00100: r = x - y;
      5'b00101: r = x - z;
      5'b00110: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
      5'b00111: r = z & 32'hFFFF_0000;
      5'b01000: begin if (y == 0) begin r = 32'hFFFF_FFFF; d0 = 1; end else r = x / y; end
      5'b01010: r = x & y;
      5'b01011: r = x & z;
      5'b01100: r = x | y;
      5'b01101: r = x | z;
      5'b01110: r = ~x;
      5'b10000: r = x ^ y;
      5'b10001: r = x ^ z;
      5'b10010: r = x - y;
      5'b11100: r = y + z;
      5'b11101: r = x + z;
      5'b11110: r = z & 32'h0000_FFFF;
      default:  il = 1;
    endcase
    return {il, d0, r[31], (r == 0), r};
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [4:0] op, input logic [31:0] x, y, z);
    int w;
    @(negedge clk);
    opcode = op; a = x; b = y; imm = z; in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 200) begin @(negedge clk); #1; w++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", w);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // counts negedges after the accept edge until out_valid; busy counts
  // negedges where the unit was stalling (in_ready=0, out_valid=0)
  task automatic wait_result(input int maxc, output int cyc, output int busy);
    cyc = 0; busy = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
      if (!in_ready && !out_valid) busy++;
    end while (!out_valid && cyc < maxc);
    if (!out_valid) begin
      n_chk++; n_fail++;
      $display("FAIL result_timeout: no out_valid after %0d cycles", cyc);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] x, y, z;
    logic [31:0] res;
    logic [1:0]  fl;
    logic        d0;
    logic        il;
  } vec_t;

  vec_t vecs[$];
  logic [35:0] exp_q[$];

  initial begin
    int cyc, busy;
    logic [35:0] e;

    // fixed expectations computed by hand
    vecs.push_back('{5'b11111, 32'h1234, 32'h5678, 32'h9, 32'h0,          2'b01, 1'b0, 1'b1});
    vecs.push_back('{5'b11100, 32'h7,    32'h1000, 32'h10, 32'h1010,      2'b00, 1'b0, 1'b0});
    vecs.push_back('{5'b00110, 32'h10000,32'h10000,32'h0, 32'h0,          2'b01, 1'b0, 1'b0});
    vecs.push_back('{5'b00110, 32'h3,    32'h5,    32'h0, 32'hF,          2'b00, 1'b0, 1'b0});
    vecs.push_back('{5'b01110, 32'h0,    32'h5,    32'h0, 32'hFFFF_FFFF,  2'b10, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 32'hF0F0, 32'h1,    32'hFFFF, 32'h0F0F,    2'b00, 1'b0, 1'b0});
    vecs.push_back('{5'b00111, 32'h1,    32'h2,    32'h1234_5678, 32'h1234_0000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{5'b01101, 32'h100,  32'hFF,   32'h1, 32'h101,        2'b00, 1'b0, 1'b0});
    vecs.push_back('{5'b01011, 32'hFF,   32'h0,    32'hF, 32'hF,          2'b00, 1'b0, 1'b0});
    vecs.push_back('{5'b10010, 32'h5,    32'h5,    32'h9, 32'h0,          2'b01, 1'b0, 1'b0});
    vecs.push_back('{5'b00101, 32'hA,    32'h0,    32'h3, 32'h7,          2'b00, 1'b0, 1'b0});
    vecs.push_back('{5'b11101, 32'h20,   32'h99,   32'h4, 32'h24,         2'b00, 1'b0, 1'b0});
    vecs.push_back('{5'b01000, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'h0FFF_FFFF, 2'b00, 1'b0, 1'b0});

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready",  in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result",    result, 0);
    chk("reset_flags",     flags, 0);
    chk("reset_div0",      div0, 0);
    chk("reset_illegal",   illegal, 0);

    // ---------------- ADD wrap ----------------
    issue(5'b00010, 32'hFFFF_FFFF, 32'h1, 32'h0);
    wait_result(5, cyc, busy);
    chk("add_latency", cyc, 1);
    chk("add_result", result, 0);
    chk("add_flags", flags, 2'b01);

    // ---------------- back-to-back ADDI / MOVEL ----------------
    @(negedge clk);
    opcode = 5'b00011; a = 5; b = 0; imm = 32'hFFFF_FFFE; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("b2b_ready0", in_ready, 1);
    @(negedge clk);
    opcode = 5'b11110; a = 0; imm = 32'h1234_5678;
    #1;
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_result1", result, 3);
    chk("b2b_ready1", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_result2", result, 32'h0000_5678);

    // ---------------- divides ----------------
    issue(5'b01000, 32'd100, 32'd7, 32'h0);
    wait_result(60, cyc, busy);
    chk("div_latency", cyc, 33);
    chk("div_busy", busy, 32);
    chk("div_result", result, 14);
    chk("div_div0", div0, 0);
    issue(5'b01000, 32'd9, 32'd0, 32'h0);
    wait_result(60, cyc, busy);
    chk("div0_latency", cyc, 33);
    chk("div0_result", result, 32'hFFFF_FFFF);
    chk("div0_flag", div0, 1);
    chk("div0_flags", flags, 2'b10);

    // ---------------- backpressure hold ----------------
    @(negedge clk) out_ready = 1'b0;
    issue(5'b00100, 32'd3, 32'd5, 32'h0);
    wait_result(5, cyc, busy);
    for (int i = 0; i < 4; i++) begin
      chk("hold_result", result, 32'hFFFF_FFFE);
      chk("hold_flags", flags, 2'b10);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("hold_release_ready", in_ready, 1);

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].z);
      wait_result(60, cyc, busy);
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), flags, vecs[i].fl);
      chk($sformatf("vec%0d_div0", i), div0, vecs[i].d0);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].il);
    end

    // ---------------- reset mid-divide ----------------
    issue(5'b01000, 32'd1000, 32'd3, 32'h0);
    repeat (9) @(negedge clk);
    #1 chk("middiv_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("middiv_rst_valid", out_valid, 0);
    chk("middiv_rst_result", result, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("middiv_rel_ready", in_ready, 1);
    issue(5'b00010, 32'd2, 32'd2, 32'h0);
    wait_result(5, cyc, busy);
    chk("middiv_add_latency", cyc, 1);
    chk("middiv_add_result", result, 4);

    // ---------------- randomized stream vs model ----------------
    begin
      logic [4:0] ops[19] = '{5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                              5'b00111, 5'b01000, 5'b01010, 5'b01011, 5'b01100,
                              5'b01101, 5'b01110, 5'b10000, 5'b10001, 5'b10010,
                              5'b11100, 5'b11101, 5'b11110, 5'b11111};
      logic accepted = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
        if (!in_valid || accepted) begin
          in_valid = ($urandom_range(0, 3) != 0);
          opcode = ops[$urandom_range(0, 18)];
          if (opcode == 5'b01000 && $urandom_range(0, 3) != 0) opcode = 5'b00010;
          a   = $urandom();
          b   = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom() : 32'($urandom_range(1, 300)));
          imm = $urandom();
        end
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rand_unexpected: result 0x%0h with empty queue", result);
          end else begin
            e = exp_q.pop_front();
            chk("rand_out", {illegal, div0, flags, result}, e);
          end
        end
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(model(opcode, a, b, imm));
        @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
        #1;
        if (out_valid) begin
          e = exp_q.pop_front();
          chk("drain_out", {illegal, div0, flags, result}, e);
        end
        @(negedge clk);
      end
      chk("drain_empty", exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
